// File: rtl/dct_quant_zigzag.sv
// Captures an 8x8 DCT coefficient block, quantizes it with a per-position
// power-of-two shift and streams it out in JPEG zigzag order.
module dct_quant_zigzag #(
  parameter int V     = 14,
  parameter int Q     = 12,
  parameter int QBASE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dct_finish,
  input  logic [7:0][7:0][V-1:0]   coef_in,
  output logic                     hold_end,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [Q-1:0]      out_data,
  output logic [5:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SEND
  } state_t;

  localparam int MW   = V + 2;
  localparam int QMAX = 2 ** (Q - 1) - 1;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [63:0][V-1:0]    buf_q, buf_d;
  logic                  load;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dct_finish) begin
          load    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        idx_d   = '0;
        state_d = SEND;
        if (dct_finish) pending_d = 1'b1;
      end
      SEND: begin
        if (dct_finish) pending_d = 1'b1;
        if (out_ready) begin
          idx_d = idx_q + 6'd1;
          // a finish landing on the last beat is taken straight away
          if (idx_q == 6'd63) begin
            if (pending_q || dct_finish) begin
              load      = 1'b1;
              pending_d = 1'b0;
              state_d   = ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    buf_d = load ? coef_in : buf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      buf_q     <= buf_d;
    end
  end

  logic [5:0]        lin;
  logic [V-1:0]      c_raw;
  logic              neg;
  logic [3:0]        uv;
  int                s_i;
  logic [2:0]        sh;
  logic [MW-1:0]     m, rnd, qm;
  logic [Q-1:0]      q;

  always_comb begin
    lin   = ZZ[idx_q];
    c_raw = buf_q[lin];
    neg   = c_raw[V-1];
    uv    = {1'b0, lin[5:3]} + {1'b0, lin[2:0]};
    s_i   = QBASE + int'(uv >> 2);
    if (s_i > 7) s_i = 7;
    if (s_i < 0) s_i = 0;
    sh    = 3'(s_i);
    m     = neg ? (MW'(0) - {{2{c_raw[V-1]}}, c_raw})
                : {2'b00, c_raw};
    rnd   = (sh == 3'd0) ? '0 : (MW'(1) << (sh - 3'd1));
    qm    = (m + rnd) >> sh;
    if (neg) begin
      if (qm > MW'(QMAX + 1)) q = {1'b1, {(Q-1){1'b0}}};
      else                    q = Q'(MW'(0) - qm);
    end else begin
      if (qm > MW'(QMAX)) q = {1'b0, {(Q-1){1'b1}}};
      else                q = qm[Q-1:0];
    end
  end

  assign busy      = (state_q != IDLE);
  assign hold_end  = (state_q == ACK);
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? $signed(q) : '0;
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_last  = out_valid && (idx_q == 6'd63);

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Randomized bench for dct_quant_zigzag against a plain-arithmetic
// quantization and zigzag reference.
module tb_dct_quant_zigzag;

  localparam int V  = 14;
  localparam int Q  = 12;
  localparam int QB = 2;

  logic                   clk;
  logic                   rst;
  logic                   dct_finish;
  logic [7:0][7:0][V-1:0] coef_in;
  logic                   hold_end;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [Q-1:0]    out_data;
  logic [5:0]             out_idx;
  logic                   out_last;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  int zz [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int cur [64];
  int nxt [64];
  int first;

  dct_quant_zigzag #(.V(V), .Q(Q), .QBASE(QB)) dut (
    .clk        (clk),
    .rst        (rst),
    .dct_finish (dct_finish),
    .coef_in    (coef_in),
    .hold_end   (hold_end),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qref(input int c, input int lin);
    int s, m, qm, r;
    s = QB + (((lin / 8) + (lin % 8)) / 4);
    if (s > 7) s = 7;
    if (s < 0) s = 0;
    m  = (c < 0) ? -c : c;
    qm = (s > 0) ? (m + (1 << (s - 1))) / (1 << s) : m;
    r  = (c < 0) ? -qm : qm;
    if (r > 2 ** (Q - 1) - 1) r = 2 ** (Q - 1) - 1;
    if (r < -(2 ** (Q - 1))) r = -(2 ** (Q - 1));
    return r;
  endfunction

  task automatic drive(input int c [64]);
    for (int i = 0; i < 64; i++)
      coef_in[i / 8][i % 8] = V'(c[i]);
  endtask

  task automatic rand_fill(output int c [64]);
    for (int i = 0; i < 64; i++)
      c[i] = int'($urandom_range(0, 16383)) - 8192;
  endtask

  // called at a negedge with the DUT idle; returns at the first SEND negedge
  task automatic start_block(input int c [64]);
    drive(c);
    dct_finish = 1'b1;
    @(negedge clk);
    dct_finish = 1'b0;
    chk("hold_end_ack", int'(hold_end), 1);
    chk("valid_ack", int'(out_valid), 0);
    chk("busy_ack", int'(busy), 1);
    @(negedge clk);
  endtask

  task automatic stream(input int c [64], input bit rnd,
                        input int inj, output int f);
    int beats = 0;
    int cyc = 0;
    int pd = 0;
    int pi = 0;
    bit stalled = 1'b0;
    int e;
    f = 0;
    while (beats < 64) begin
      if (cyc >= 2000) begin
        chk("stream_timeout", beats, 64);
        break;
      end
      chk("hold_end_send", int'(hold_end), 0);
      chk("valid_send", int'(out_valid), 1);
      if (out_valid) begin
        e = qref(c[zz[beats]], zz[beats]);
        chk("idx", int'(out_idx), beats);
        chk("data", int'(out_data), e);
        chk("last", int'(out_last), int'(beats == 63));
        if (stalled) begin
          chk("stall_data", int'(out_data), pd);
          chk("stall_idx", int'(out_idx), pi);
        end
        if (beats == 0) f = int'(out_data);
      end
      if (cyc == inj) begin
        drive(nxt);
        dct_finish = 1'b1;
      end else begin
        dct_finish = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = out_valid && !out_ready;
      pd = int'(out_data);
      pi = int'(out_idx);
      if (out_valid && out_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    dct_finish = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_hold"}, int'(hold_end), 0);
  endtask

  task automatic one_block(input bit rnd);
    start_block(cur);
    stream(cur, rnd, -1, first);
    check_idle("post");
  endtask

  initial begin
    rst        = 1'b1;
    dct_finish = 1'b0;
    out_ready  = 1'b0;
    coef_in    = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", int'(hold_end), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // ramp block, ready held high
    for (int i = 0; i < 64; i++) cur[i] = i;
    one_block(1'b0);

    // rounding and sign at (0,0), shift 2
    rand_fill(cur); cur[0] = -6; one_block(1'b0);
    chk("round_m6", first, -2);
    rand_fill(cur); cur[0] = -5; one_block(1'b0);
    chk("round_m5", first, -1);
    rand_fill(cur); cur[0] = 6; one_block(1'b0);
    chk("round_p6", first, 2);
    rand_fill(cur); cur[0] = -1; one_block(1'b0);
    chk("round_m1", first, 0);

    // extremes
    rand_fill(cur); cur[0] = -8192; cur[63] = -8192;
    one_block(1'b0);
    chk("ext_min", first, -2048);
    rand_fill(cur); cur[0] = 8191; cur[63] = 8191;
    one_block(1'b0);
    chk("ext_max", first, 2047);

    // random data with random backpressure
    for (int b = 0; b < 4; b++) begin
      rand_fill(cur);
      one_block(1'b1);
    end

    // back-to-back: second finish ten cycles into SEND
    rand_fill(cur);
    rand_fill(nxt);
    start_block(cur);
    stream(cur, 1'b0, 10, first);
    chk("b2b_hold", int'(hold_end), 1);
    chk("b2b_valid", int'(out_valid), 0);
    @(negedge clk);
    stream(nxt, 1'b1, -1, first);
    check_idle("b2b_post");

    // reset in the middle of a stream
    rand_fill(cur);
    start_block(cur);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hold", int'(hold_end), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_idx", int'(out_idx), 0);
    chk("mid_rst_last", int'(out_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_idle("after_rst");
    @(negedge clk);
    check_idle("after_rst2");

    // recovers normally after the abort
    rand_fill(cur);
    one_block(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
